// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon-MM bus arbiter.
// The macro ARB_TIMEOUT_EN (see mips_bus_arbiter.sv) uses TIMEOUT_RDATA.
package mips_bus_pkg;
    typedef enum logic [1:0] {IDLE, BUS, RESP} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam logic [3:0]  BE_WORD       = 4'hF;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mips_bus_arbiter_rr_picker.sv
// Combinational two-way round-robin picker: on contention the requester
// that was not served last wins.
module arb_rr_picker
    import mips_bus_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant_owner = OWN_I;
        if (req_i && req_d)
            grant_owner = (last == OWN_I) ? OWN_D : OWN_I;
        else if (req_d)
            grant_owner = OWN_D;
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one Avalon-MM master.
// Optional `define ARB_TIMEOUT_EN adds a stall timeout with i_err/d_err pulses.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter bit RESET_LAST_D = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [ADDR_W-1:0] i_readdata,
    output logic              i_done,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_writedata,
    input  logic [3:0]        d_byteenable,
    output logic [ADDR_W-1:0] d_readdata,
    output logic              d_done,
`ifdef ARB_TIMEOUT_EN
    output logic              i_err,
    output logic              d_err,
`endif
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [ADDR_W-1:0] writedata,
    output logic [3:0]        byteenable,
    input  logic [ADDR_W-1:0] readdata
);

    localparam owner_t LAST_RST = RESET_LAST_D ? OWN_D : OWN_I;

    arb_state_t        state, state_nx;
    owner_t            last, last_nx;
    owner_t            owner, owner_nx;
    logic [ADDR_W-1:0] address_nx, writedata_nx, i_readdata_nx, d_readdata_nx;
    logic [3:0]        byteenable_nx;
    logic              read_nx, write_nx, i_done_nx, d_done_nx;
    logic              grant_valid;
    owner_t            grant_owner;

`ifdef ARB_TIMEOUT_EN
    localparam int         TIMEOUT_CYCLES = 1024;
    // Fires on the stalled edge that would bring the count to TIMEOUT_CYCLES-1.
    localparam logic [9:0] TO_LAST        = 10'(TIMEOUT_CYCLES - 2);

    logic [9:0] to_cnt, to_cnt_nx;
    logic       i_err_nx, d_err_nx;
`endif

    arb_rr_picker u_picker (
        .req_i       (i_read),
        .req_d       (d_read | d_write),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_nx      = state;
        last_nx       = last;
        owner_nx      = owner;
        address_nx    = address;
        writedata_nx  = writedata;
        byteenable_nx = byteenable;
        read_nx       = 1'b0;
        write_nx      = 1'b0;
        i_readdata_nx = i_readdata;
        d_readdata_nx = d_readdata;
        i_done_nx     = 1'b0;
        d_done_nx     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        to_cnt_nx     = to_cnt;
        i_err_nx      = 1'b0;
        d_err_nx      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nx = BUS;
                    owner_nx = grant_owner;
                    last_nx  = grant_owner;
`ifdef ARB_TIMEOUT_EN
                    to_cnt_nx = '0;
`endif
                    if (grant_owner == OWN_I) begin
                        address_nx    = i_addr;
                        byteenable_nx = BE_WORD;
                        read_nx       = 1'b1;
                    end else begin
                        // A simultaneous read and write is serviced as a write.
                        address_nx    = d_addr;
                        writedata_nx  = d_writedata;
                        byteenable_nx = d_byteenable;
                        write_nx      = d_write;
                        read_nx       = ~d_write;
                    end
                end
            end
            BUS: begin
                read_nx  = read;
                write_nx = write;
                if (!waitrequest) begin
                    read_nx  = 1'b0;
                    write_nx = 1'b0;
                    state_nx = RESP;
                    if (owner == OWN_I) begin
                        i_readdata_nx = readdata;
                        i_done_nx     = 1'b1;
                    end else begin
                        if (!write)
                            d_readdata_nx = readdata;
                        d_done_nx = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    read_nx  = 1'b0;
                    write_nx = 1'b0;
                    state_nx = RESP;
                    if (owner == OWN_I) begin
                        i_readdata_nx = ADDR_W'(TIMEOUT_RDATA);
                        i_done_nx     = 1'b1;
                        i_err_nx      = 1'b1;
                    end else begin
                        d_readdata_nx = ADDR_W'(TIMEOUT_RDATA);
                        d_done_nx     = 1'b1;
                        d_err_nx      = 1'b1;
                    end
                end else begin
                    to_cnt_nx = to_cnt + 10'd1;
                end
`endif
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last       <= LAST_RST;
            owner      <= OWN_I;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            i_readdata <= '0;
            d_readdata <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            to_cnt     <= '0;
            i_err      <= 1'b0;
            d_err      <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            last       <= last_nx;
            owner      <= owner_nx;
            address    <= address_nx;
            writedata  <= writedata_nx;
            byteenable <= byteenable_nx;
            read       <= read_nx;
            write      <= write_nx;
            i_readdata <= i_readdata_nx;
            d_readdata <= d_readdata_nx;
            i_done     <= i_done_nx;
            d_done     <= d_done_nx;
`ifdef ARB_TIMEOUT_EN
            to_cnt     <= to_cnt_nx;
            i_err      <= i_err_nx;
            d_err      <= d_err_nx;
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset) assert (!(d_read && d_write));
    end
`endif

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: scoreboard of expected completions
// popped on each done pulse, plus direct bus-signal checks.
module tb_mips_bus_arbiter;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_writedata = '0;
    logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [3:0]  d_byteenable = '0;
    logic [31:0] i_readdata, d_readdata, address, writedata, readdata;
    logic        i_done, d_done, read, write;
    logic [3:0]  byteenable;
    logic        waitrequest = 1'b0;
    logic        rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr = '0;
`ifdef ARB_TIMEOUT_EN
    logic        i_err, d_err;
`endif

    typedef struct {
        logic        own_d;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   done_cyc_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    assign readdata = rd_ovr_en ? rd_ovr : (address ^ KEY);

    mips_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_addr       (i_addr),
        .i_read       (i_read),
        .i_readdata   (i_readdata),
        .i_done       (i_done),
        .d_addr       (d_addr),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_writedata  (d_writedata),
        .d_byteenable (d_byteenable),
        .d_readdata   (d_readdata),
        .d_done       (d_done),
`ifdef ARB_TIMEOUT_EN
        .i_err        (i_err),
        .d_err        (d_err),
`endif
        .address      (address),
        .read         (read),
        .write        (write),
        .waitrequest  (waitrequest),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .readdata     (readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse retires the oldest expected completion.
    always @(negedge clk) begin
        if (reset && (i_done || d_done)) begin
            check_val("single_done", {31'b0, i_done & d_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", {31'b0, i_done | d_done}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("done_owner", {31'b0, d_done}, {31'b0, e.own_d});
                check_val("done_data", d_done ? d_readdata : i_readdata, e.data);
            end
            done_cyc_q.push_back(cyc);
        end
    end

    initial begin
        bit found;
        // Reset state
        tick;
        tick;
        check_val("rst_read", {31'b0, read}, 32'd0);
        check_val("rst_write", {31'b0, write}, 32'd0);
        check_val("rst_done", {30'b0, i_done, d_done}, 32'd0);
        check_val("rst_address", address, 32'd0);
        check_val("rst_writedata", writedata, 32'd0);
        check_val("rst_byteenable", {28'b0, byteenable}, 32'd0);
        check_val("rst_i_readdata", i_readdata, 32'd0);
        check_val("rst_d_readdata", d_readdata, 32'd0);
        reset = 1'b1;
        tick;

        // Minimum-latency instruction fetch
        rd_ovr_en = 1'b1;
        rd_ovr    = 32'h2402_0005;
        i_addr    = 32'hBFC0_0000;
        i_read    = 1'b1;
        exp_q.push_back('{1'b0, 32'h2402_0005});
        tick;
        check_val("t1_read", {31'b0, read}, 32'd1);
        check_val("t1_address", address, 32'hBFC0_0000);
        check_val("t1_byteenable", {28'b0, byteenable}, 32'hF);
        tick;
        check_val("t1_i_done", {31'b0, i_done}, 32'd1);
        check_val("t1_i_readdata", i_readdata, 32'h2402_0005);
        i_read = 1'b0;
        tick;
        check_val("t1_done_drop", {31'b0, i_done}, 32'd0);
        rd_ovr_en = 1'b0;

        // Stalled data store: bus held for 6 cycles, d_readdata untouched
        d_addr       = 32'h0000_1000;
        d_writedata  = 32'hCAFE_F00D;
        d_byteenable = 4'b0011;
        d_write      = 1'b1;
        waitrequest  = 1'b1;
        exp_q.push_back('{1'b1, 32'h0});
        for (int k = 0; k < 6; k++) begin
            tick;
            check_val("t2_write", {31'b0, write}, 32'd1);
            check_val("t2_address", address, 32'h0000_1000);
            check_val("t2_byteenable", {28'b0, byteenable}, 32'h3);
            check_val("t2_writedata", writedata, 32'hCAFE_F00D);
            check_val("t2_no_done", {31'b0, d_done}, 32'd0);
        end
        waitrequest = 1'b0;
        tick;
        check_val("t2_d_done", {31'b0, d_done}, 32'd1);
        check_val("t2_write_drop", {31'b0, write}, 32'd0);
        check_val("t2_d_readdata", d_readdata, 32'h0);
        d_write = 1'b0;
        tick;

        // Data load with the requester address changing mid-stall
        d_addr      = 32'h0000_3000;
        d_read      = 1'b1;
        waitrequest = 1'b1;
        exp_q.push_back('{1'b1, 32'h0000_3000 ^ KEY});
        tick;
        check_val("t3_read", {31'b0, read}, 32'd1);
        tick;
        tick;
        d_addr = 32'h0000_2000;
        tick;
        check_val("t3_addr_held", address, 32'h0000_3000);
        waitrequest = 1'b0;
        tick;
        check_val("t3_d_done", {31'b0, d_done}, 32'd1);
        check_val("t3_d_readdata", d_readdata, 32'h0000_3000 ^ KEY);
        d_read = 1'b0;
        tick;

        // Both requesters held after reset: I, D, I every 3 cycles
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        done_cyc_q.delete();
        i_addr = 32'h0000_0400;
        d_addr = 32'h0000_0800;
        i_read = 1'b1;
        d_read = 1'b1;
        exp_q.push_back('{1'b0, 32'h0000_0400 ^ KEY});
        exp_q.push_back('{1'b1, 32'h0000_0800 ^ KEY});
        exp_q.push_back('{1'b0, 32'h0000_0400 ^ KEY});
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick;
            if (done_cyc_q.size() >= 3) found = 1'b1;
        end
        i_read = 1'b0;
        d_read = 1'b0;
        check_val("t4_three_done", {31'b0, found}, 32'd1);
        if (done_cyc_q.size() >= 3) begin
            check_val("t4_gap0", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'd3);
            check_val("t4_gap1", 32'(done_cyc_q[2] - done_cyc_q[1]), 32'd3);
        end
        tick;
        tick;
        tick;
        check_val("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during a stalled fetch: strobes drop at once, no done
        i_addr      = 32'h0000_0500;
        i_read      = 1'b1;
        waitrequest = 1'b1;
        tick;
        tick;
        check_val("t5_read_before", {31'b0, read}, 32'd1);
        reset = 1'b0;
        #1;
        check_val("t5_read_async", {31'b0, read}, 32'd0);
        check_val("t5_write_async", {31'b0, write}, 32'd0);
        tick;
        tick;
        check_val("t5_no_done", {30'b0, i_done, d_done}, 32'd0);
        reset       = 1'b1;
        waitrequest = 1'b0;
        exp_q.push_back('{1'b0, 32'h0000_0500 ^ KEY});
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick;
            if (i_done) found = 1'b1;
        end
        check_val("t5_serviced", {31'b0, found}, 32'd1);
        i_read = 1'b0;
        tick;
        tick;

`ifdef ARB_TIMEOUT_EN
        // Stuck slave: timeout completes the load with an error pulse
        begin
            int n;
            n = 0;
            found = 1'b0;
            d_addr      = 32'h0000_6000;
            d_read      = 1'b1;
            waitrequest = 1'b1;
            exp_q.push_back('{1'b1, 32'hDEAD_BEEF});
            for (int k = 0; k < 1100 && !found; k++) begin
                tick;
                n++;
                if (d_done) found = 1'b1;
            end
            check_val("t6_done", {31'b0, found}, 32'd1);
            check_val("t6_latency", 32'(n - 1), 32'd1023);
            check_val("t6_d_err", {31'b0, d_err}, 32'd1);
            check_val("t6_i_err", {31'b0, i_err}, 32'd0);
            check_val("t6_read_drop", {31'b0, read}, 32'd0);
            d_read = 1'b0;
            tick;
            check_val("t6_err_drop", {31'b0, d_err}, 32'd0);
            waitrequest = 1'b0;
            tick;
            tick;
        end
`endif

        check_val("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
